// File: rtl/resolvedor_disparo.sv
// resolvedor_disparo: resolves one shot against a player's fleet memory.
// Scans the fleet words of the target player. The first valid cell that matches
// the shot decides the outcome: water, hit, repeated or invalid. On a new hit the
// updated word (cell marked, count-1) is written back in a single one-cycle pulse.
module resolvedor_disparo #(
    parameter int N_NAVIOS = 11,
    parameter int TAM_TAB  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disparo,
    input  logic [3:0]  x1,
    input  logic [3:0]  y1,
    input  logic        jogador,
    input  logic [63:0] vetor_leitura1,
    input  logic [63:0] vetor_leitura2,
    output logic [4:0]  read_addr,
    output logic [4:0]  write_addr,
    output logic [63:0] vetor,
    output logic        wrep1,
    output logic        wrep2,
    output logic        ocupado,
    output logic        pronto,
    output logic        acerto,
    output logic        agua,
    output logic        repetido,
    output logic        invalido,
    output logic        afundou,
    output logic [2:0]  tipo_afundado,
    output logic        frota_destruida
);

    localparam int         N_CEL = 5;
    localparam logic [4:0] ULT   = 5'(N_NAVIOS - 1);

    typedef enum logic [1:0] {IDLE, LER, GRAVA, FIM} estado_t;

    estado_t estado, prox_estado;

    // latched shot
    logic [3:0]  x_l, y_l;
    logic        jog_l;

    // compare stage: data on the read bus belongs to cmp_addr when cmp_vld
    logic        cmp_vld;
    logic [4:0]  cmp_addr;

    // running winner and alive tally
    logic        achou;
    logic [4:0]  win_addr;
    logic        win_rep;
    logic [63:0] win_word;
    logic        win_afunda;
    logic [2:0]  win_tipo;
    logic [4:0]  vivos;
    logic        algum;

    // decode of the word currently on the read bus
    logic [63:0]      rdata;
    logic [2:0]       tipo;
    logic [3:0]       cont;
    logic [4:0]       masc;
    logic [2:0]       n_cel;
    logic             palavra_ok;
    logic [N_CEL-1:0] cel_hit;

    // compare result merged with the running winner
    logic        tem_match;
    logic [2:0]  k_sel;
    logic        ja_atingido;
    logic        novo;
    logic [63:0] upd;
    logic        f_achou;
    logic [4:0]  f_addr;
    logic        f_rep;
    logic [63:0] f_word;
    logic        f_afunda;
    logic [2:0]  f_tipo;
    logic [4:0]  f_vivos;
    logic        f_algum;
    logic        tiro_fora;

    assign rdata      = jog_l ? vetor_leitura2 : vetor_leitura1;
    assign tipo       = rdata[2:0];
    assign cont       = rdata[46:43];
    assign masc       = rdata[51:47];
    assign palavra_ok = (cont != 4'd0) || (masc != 5'd0);
    assign tiro_fora  = (32'(x1) >= 32'(TAM_TAB)) || (32'(y1) >= 32'(TAM_TAB));

    // number of meaningful cells for each ship type; unknown types have none
    always_comb begin
        n_cel = 3'd0;
        case (tipo)
            3'd0:    n_cel = 3'd5;
            3'd1:    n_cel = 3'd4;
            3'd2:    n_cel = 3'd3;
            3'd3:    n_cel = 3'd2;
            3'd4:    n_cel = 3'd1;
            default: n_cel = 3'd0;
        endcase
    end

    // per-cell coordinate match; cells past n_cel are never compared
    generate
        for (genvar k = 0; k < N_CEL; k++) begin : g_cel
            assign cel_hit[k] = palavra_ok && (3'(k) < n_cel) &&
                                (rdata[6+8*k -: 4] == x_l) &&
                                (rdata[10+8*k -: 4] == y_l);
        end
    endgenerate

    // pick the lowest matching cell and fold it into the running winner/tally
    always_comb begin
        tem_match = 1'b0;
        k_sel     = 3'd0;
        for (int k = N_CEL - 1; k >= 0; k--) begin
            if (cel_hit[k]) begin
                tem_match = 1'b1;
                k_sel     = 3'(k);
            end
        end

        // count already 0 with the bit clear is a corrupt word: treated as repeated
        ja_atingido = masc[k_sel] || (cont == 4'd0);
        novo        = cmp_vld && tem_match && !achou;

        upd          = rdata;
        upd[51:47]   = masc | (5'd1 << k_sel);
        upd[46:43]   = cont - 4'd1;

        f_achou  = achou || novo;
        f_addr   = novo ? cmp_addr : win_addr;
        f_rep    = novo ? ja_atingido : win_rep;
        f_word   = novo ? upd : win_word;
        f_afunda = novo ? (!ja_atingido && (cont == 4'd1)) : win_afunda;
        f_tipo   = novo ? tipo : win_tipo;

        f_vivos = vivos;
        f_algum = algum;
        if (cmp_vld && palavra_ok) begin
            f_algum = 1'b1;
            if (novo && !ja_atingido) begin
                if (cont != 4'd1) f_vivos = vivos + 5'd1;
            end else if (cont != 4'd0) begin
                f_vivos = vivos + 5'd1;
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) estado <= IDLE;
        else        estado <= prox_estado;
    end

    // next-state: out-of-board shots skip the scan entirely
    always_comb begin
        prox_estado = estado;
        case (estado)
            IDLE:    if (disparo) prox_estado = tiro_fora ? FIM : LER;
            LER:     if (read_addr == ULT) prox_estado = GRAVA;
            GRAVA:   prox_estado = FIM;
            FIM:     prox_estado = IDLE;
            default: prox_estado = IDLE;
        endcase
    end

    // datapath: address stepping, compare pipeline, result flags and write-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_l             <= '0;
            y_l             <= '0;
            jog_l           <= 1'b0;
            cmp_vld         <= 1'b0;
            cmp_addr        <= '0;
            achou           <= 1'b0;
            win_addr        <= '0;
            win_rep         <= 1'b0;
            win_word        <= '0;
            win_afunda      <= 1'b0;
            win_tipo        <= '0;
            vivos           <= '0;
            algum           <= 1'b0;
            read_addr       <= '0;
            write_addr      <= '0;
            vetor           <= '0;
            wrep1           <= 1'b0;
            wrep2           <= 1'b0;
            ocupado         <= 1'b0;
            pronto          <= 1'b0;
            acerto          <= 1'b0;
            agua            <= 1'b0;
            repetido        <= 1'b0;
            invalido        <= 1'b0;
            afundou         <= 1'b0;
            tipo_afundado   <= '0;
            frota_destruida <= 1'b0;
        end else begin
            pronto   <= 1'b0;
            wrep1    <= 1'b0;
            wrep2    <= 1'b0;
            cmp_vld  <= (estado == LER);
            cmp_addr <= read_addr;

            if (cmp_vld) begin
                achou      <= f_achou;
                win_addr   <= f_addr;
                win_rep    <= f_rep;
                win_word   <= f_word;
                win_afunda <= f_afunda;
                win_tipo   <= f_tipo;
                vivos      <= f_vivos;
                algum      <= f_algum;
            end

            case (estado)
                IDLE: begin
                    if (disparo) begin
                        x_l             <= x1;
                        y_l             <= y1;
                        jog_l           <= jogador;
                        ocupado         <= 1'b1;
                        acerto          <= 1'b0;
                        agua            <= 1'b0;
                        repetido        <= 1'b0;
                        afundou         <= 1'b0;
                        tipo_afundado   <= '0;
                        frota_destruida <= 1'b0;
                        invalido        <= tiro_fora;
                        achou           <= 1'b0;
                        vivos           <= '0;
                        algum           <= 1'b0;
                        if (!tiro_fora) read_addr <= '0;
                    end
                end
                LER: begin
                    if (read_addr != ULT) read_addr <= read_addr + 5'd1;
                end
                GRAVA: begin
                    // last address is still being compared here, so use the merged result
                    acerto   <= f_achou && !f_rep;
                    repetido <= f_achou && f_rep;
                    agua     <= !f_achou;
                    afundou  <= f_achou && !f_rep && f_afunda;
                    if (f_achou && !f_rep) begin
                        tipo_afundado <= f_afunda ? f_tipo : 3'd0;
                        write_addr    <= f_addr;
                        vetor         <= f_word;
                        wrep1         <= !jog_l;
                        wrep2         <= jog_l;
                    end
                end
                FIM: begin
                    pronto          <= 1'b1;
                    ocupado         <= 1'b0;
                    frota_destruida <= (vivos == 5'd0) && algum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_resolvedor_disparo.sv
// Directed bench for resolvedor_disparo with two registered-read fleet RAM models.
module tb_resolvedor_disparo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disparo;
    logic [3:0]  x1, y1;
    logic        jogador;
    logic [63:0] vetor_leitura1, vetor_leitura2;
    logic [4:0]  read_addr, write_addr;
    logic [63:0] vetor;
    logic        wrep1, wrep2, ocupado, pronto;
    logic        acerto, agua, repetido, invalido, afundou, frota_destruida;
    logic [2:0]  tipo_afundado;

    resolvedor_disparo dut (
        .clk(clk), .rst_n(rst_n), .disparo(disparo), .x1(x1), .y1(y1),
        .jogador(jogador), .vetor_leitura1(vetor_leitura1), .vetor_leitura2(vetor_leitura2),
        .read_addr(read_addr), .write_addr(write_addr), .vetor(vetor),
        .wrep1(wrep1), .wrep2(wrep2), .ocupado(ocupado), .pronto(pronto),
        .acerto(acerto), .agua(agua), .repetido(repetido), .invalido(invalido),
        .afundou(afundou), .tipo_afundado(tipo_afundado), .frota_destruida(frota_destruida)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] ALTO = 64'hABC0_0000_0000_0000;

    // RAM models with a load port for the bench
    logic [63:0] mem1 [0:31];
    logic [63:0] mem2 [0:31];
    logic        ld_clr = 1'b0, ld_en = 1'b0, ld_sel = 1'b0;
    logic [4:0]  ld_a = '0;
    logic [63:0] ld_d = '0;

    always @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 32; i++) begin
                mem1[i] <= '0;
                mem2[i] <= '0;
            end
        end else if (ld_en) begin
            if (ld_sel) mem2[ld_a] <= ld_d;
            else        mem1[ld_a] <= ld_d;
        end
        if (wrep1) mem1[write_addr] <= vetor;
        if (wrep2) mem2[write_addr] <= vetor;
        vetor_leitura1 <= mem1[read_addr];
        vetor_leitura2 <= mem2[read_addr];
    end

    // cycle counter and write monitor
    int          cyc = 0;
    int          t_acc = 0;
    int          wr_total = 0;
    int          wr_rel = 0;
    logic [4:0]  wr_a = '0;
    logic [63:0] wr_d = '0;
    logic        wr_p2 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wrep1 || wrep2) begin
            wr_total = wr_total + 1;
            wr_rel   = cyc - t_acc + 1;
            wr_a     = write_addr;
            wr_d     = vetor;
            wr_p2    = wrep2;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_chk++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, esp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [2:0] t, input logic [3:0] c,
                                       input logic [4:0] m, input logic [19:0] xs,
                                       input logic [19:0] ys);
        logic [63:0] w;
        w = '0;
        w[2:0] = t;
        for (int k = 0; k < 5; k++) begin
            w[3+8*k +: 4] = xs[4*k +: 4];
            w[7+8*k +: 4] = ys[4*k +: 4];
        end
        w[46:43] = c;
        w[51:47] = m;
        return w;
    endfunction

    task automatic carrega(input logic sel, input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_sel = sel; ld_a = a; ld_d = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic limpa();
        @(negedge clk);
        ld_clr = 1'b1;
        @(negedge clk);
        ld_clr = 1'b0;
    endtask

    // fire one shot; lat is the cycle (accept edge = end of cycle 0) where pronto is seen
    task automatic tiro(input logic [3:0] x, input logic [3:0] y, input logic j,
                        output int lat, output int nwr);
        int n;
        int base;
        @(negedge clk);
        x1 = x; y1 = y; jogador = j; disparo = 1'b1;
        @(posedge clk); #1;
        t_acc = cyc; disparo = 1'b0; base = wr_total;
        n = 0;
        while (!pronto && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        lat = pronto ? n + 1 : -1;
        nwr = wr_total - base;
    endtask

    logic [19:0] cx_porta, cy_porta, cx_cruz, cy_cruz, c33, c55, c65x, c55y;
    int lat, nwr, ra0;
    int n_pronto, n_sobe, cyc_pronto1, cyc_sobe2, base;
    logic oc_ant;

    initial begin
        rst_n = 1'b0; disparo = 1'b0; x1 = '0; y1 = '0; jogador = 1'b0;
        cx_porta = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        cy_porta = {5{4'd2}};
        cx_cruz  = {12'd0, 4'd8, 4'd7};
        cy_cruz  = {12'd0, 4'd5, 4'd5};
        c33      = {16'd0, 4'd3};
        c55      = {16'd0, 4'd5};
        c65x     = {12'd0, 4'd6, 4'd5};
        c55y     = {12'd0, 4'd5, 4'd5};
        limpa();
        repeat (2) @(negedge clk);
        verifica("reset_flags", {ocupado, pronto, acerto, agua, repetido, invalido, afundou,
                                 frota_destruida, wrep1, wrep2}, '0);
        verifica("reset_addr", {tipo_afundado, read_addr, write_addr}, '0);
        verifica("reset_vetor", vetor, '0);
        rst_n = 1'b1;

        // T1: submarine at (3,3) in P2 word 0, sunk by a single shot
        carrega(1'b1, 5'd0, mk(3'd4, 4'd1, 5'd0, c33, c33));
        tiro(4'd3, 4'd3, 1'b1, lat, nwr);
        verifica("t1_lat", 64'(lat), 64'd14);
        verifica("t1_flags", {acerto, agua, repetido, invalido, afundou, frota_destruida}, 6'b100011);
        verifica("t1_tipo", 64'(tipo_afundado), 64'd4);
        verifica("t1_nwr", 64'(nwr), 64'd1);
        verifica("t1_wr", {wr_p2, wr_a, 32'(wr_rel)}, {1'b1, 5'd0, 32'd13});
        verifica("t1_vetor", wr_d, mk(3'd4, 4'd0, 5'b00001, c33, c33));
        verifica("t1_ocup", 64'(ocupado), 64'd0);

        // T2: carrier in P1 word 3, hit then repeated
        carrega(1'b0, 5'd3, mk(3'd0, 4'd5, 5'd0, cx_porta, cy_porta) | ALTO);
        carrega(1'b0, 5'd1, mk(3'd3, 4'd2, 5'd0, cx_cruz, cy_cruz));
        tiro(4'd2, 4'd2, 1'b0, lat, nwr);
        verifica("t2_lat", 64'(lat), 64'd14);
        verifica("t2_flags", {acerto, agua, repetido, invalido, afundou, frota_destruida}, 6'b100000);
        verifica("t2_wr", {64'(nwr), wr_p2, wr_a, 32'(wr_rel)}, {64'd1, 1'b0, 5'd3, 32'd13});
        verifica("t2_vetor", wr_d, mk(3'd0, 4'd4, 5'b00100, cx_porta, cy_porta) | ALTO);
        tiro(4'd2, 4'd2, 1'b0, lat, nwr);
        verifica("t2_rep_lat", 64'(lat), 64'd14);
        verifica("t2_rep_flags", {acerto, agua, repetido, invalido, afundou, frota_destruida}, 6'b001000);
        verifica("t2_rep_nwr", 64'(nwr), 64'd0);

        // T3: (0,0) only appears in the cruiser's unused cells -> water
        tiro(4'd0, 4'd0, 1'b0, lat, nwr);
        verifica("t3_lat", 64'(lat), 64'd14);
        verifica("t3_flags", {acerto, agua, repetido, invalido, afundou, frota_destruida}, 6'b010000);
        verifica("t3_nwr", 64'(nwr), 64'd0);

        // T4: off-board shot
        ra0 = int'(read_addr);
        tiro(4'd10, 4'd4, 1'b0, lat, nwr);
        verifica("t4_lat", 64'(lat), 64'd2);
        verifica("t4_flags", {acerto, agua, repetido, invalido, afundou, frota_destruida}, 6'b000100);
        verifica("t4_noread", 64'(read_addr), 64'(ra0));
        verifica("t4_nwr", 64'(nwr), 64'd0);

        // T7: two words hold (5,5); the lower address wins
        carrega(1'b1, 5'd6, mk(3'd3, 4'd2, 5'd0, c65x, c55y));
        carrega(1'b1, 5'd8, mk(3'd4, 4'd1, 5'd0, c55, c55));
        tiro(4'd5, 4'd5, 1'b1, lat, nwr);
        verifica("t7_flags", {acerto, agua, repetido, invalido, afundou, frota_destruida}, 6'b100000);
        verifica("t7_wr", {64'(nwr), wr_p2, wr_a}, {64'd1, 1'b1, 5'd6});
        verifica("t7_vetor", wr_d, mk(3'd3, 4'd1, 5'b00001, c65x, c55y));

        // T5: disparo held for 20 cycles -> back-to-back ops, second accept after pronto
        n_pronto = 0; n_sobe = 0; cyc_pronto1 = -1; cyc_sobe2 = -1; oc_ant = ocupado;
        @(negedge clk);
        x1 = 4'd9; y1 = 4'd9; jogador = 1'b0; disparo = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 20) disparo = 1'b0;
            if (pronto) begin
                n_pronto++;
                if (cyc_pronto1 < 0) cyc_pronto1 = i;
            end
            if (ocupado && !oc_ant) begin
                n_sobe++;
                if (n_sobe == 2) cyc_sobe2 = i;
            end
            oc_ant = ocupado;
        end
        verifica("t5_npronto", 64'(n_pronto), 64'd2);
        verifica("t5_naccept", 64'(n_sobe), 64'd2);
        verifica("t5_pronto1", 64'(cyc_pronto1), 64'd14);
        verifica("t5_accept2", 64'(cyc_sobe2), 64'd15);

        // T6: reset during cycle 12 of a hit drops the write
        limpa();
        carrega(1'b1, 5'd0, mk(3'd4, 4'd1, 5'd0, c33, c33));
        @(negedge clk);
        x1 = 4'd3; y1 = 4'd3; jogador = 1'b1; disparo = 1'b1;
        @(posedge clk); #1;
        t_acc = cyc; disparo = 1'b0; base = wr_total;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        verifica("t6_flags", {ocupado, pronto, acerto, agua, repetido, invalido, afundou,
                              frota_destruida, wrep1, wrep2}, '0);
        verifica("t6_addr", {tipo_afundado, read_addr, write_addr}, '0);
        verifica("t6_vetor", vetor, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        verifica("t6_nwr", 64'(wr_total - base), 64'd0);
        tiro(4'd3, 4'd3, 1'b1, lat, nwr);
        verifica("t6_after", {acerto, repetido, afundou}, 3'b101);
        verifica("t6_after_nwr", 64'(nwr), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
